// File: rtl/cnnip_conv_seq.sv
// Convolution address sequencer: walks every output window/tap of a single-channel 2D conv.
// Latency: first reads two cycles after start, tags one cycle after each read, writes MAC_LAT after mac_last.
// Backpressure: none; one tap per RUN cycle, abort flushes everything back to IDLE.
//
// Ports: start/abort/cfg_* from the controller; busy/done/err status; in_rd_*, w_rd_* memory reads;
// mac_* tags aligned with returning read data; out_wr_* feature-memory writes; perf_cycles counter.
// Optional feature: define CNNIP_SEQ_PERF_EN to build the saturating busy-cycle counter on perf_cycles.
module cnnip_conv_seq #(
    parameter int IMG_DIM = 16,
    parameter int ADDR_W  = 8,
    parameter int MAC_LAT = 2
) (
    input  logic              clk_a,
    input  logic              arstz_aq,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_kernel_size,
    input  logic [1:0]        cfg_stride,
    input  logic              cfg_padding,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_rd_addr,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic              mac_valid,
    output logic              mac_zero,
    output logic              mac_first,
    output logic              mac_last,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [15:0]       perf_cycles
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    localparam logic signed [7:0] IMG_S = IMG_DIM[7:0];

    state_t state, state_nxt;

    logic [7:0]         k_cfg;
    logic [1:0]         s_cfg;
    logic [2:0]         p_cfg;
    logic [2:0]         p_new;
    logic [2:0]         kx, ky;
    logic signed [7:0]  ox0, oy0;
    logic signed [7:0]  k_s, s_s, p_s, lim, nx, ny, ix, iy;
    logic [7:0]         drain_cnt;
    logic [MAC_LAT-1:0] wr_pipe;
    logic [ADDR_W-1:0]  wr_addr;
    logic               start_acc, k_illegal, kx_end, ky_end, x_more, y_more;
    logic               last_tap, pad_tap, run;
    int                 lin;

    assign start_acc = (state == IDLE) && start && !abort;
    // Even sizes (including 0) and anything above 7 are rejected.
    assign k_illegal = !k_cfg[0] || (k_cfg > 8'd7);
    assign p_new     = cfg_padding ? ((cfg_kernel_size[2:0] - 3'd1) >> 1) : 3'd0;

    assign k_s = $signed({5'b0, k_cfg[2:0]});
    assign s_s = $signed({6'b0, s_cfg});
    assign p_s = $signed({5'b0, p_cfg});
    assign lim = IMG_S + p_s;
    assign nx  = ox0 + s_s;
    assign ny  = oy0 + s_s;
    // Window may advance along an axis while its far edge stays inside the padded image.
    assign x_more = (nx + k_s) <= lim;
    assign y_more = (ny + k_s) <= lim;

    assign kx_end   = (kx == k_cfg[2:0] - 3'd1);
    assign ky_end   = (ky == k_cfg[2:0] - 3'd1);
    assign run      = (state == RUN);
    assign last_tap = run && kx_end && ky_end && !x_more && !y_more;

    assign ix      = ox0 + $signed({5'b0, kx});
    assign iy      = oy0 + $signed({5'b0, ky});
    assign pad_tap = (ix < 0) || (ix >= IMG_S) || (iy < 0) || (iy >= IMG_S);
    assign lin     = int'(iy) * IMG_DIM + int'(ix);

    assign busy        = (state == LOAD) || run || (state == DRAIN);
    assign done        = (state == DONE);
    assign in_rd_en    = run && !pad_tap;
    assign in_rd_addr  = (run && !pad_tap) ? ADDR_W'(lin) : '0;
    assign w_rd_en     = run;
    assign w_rd_addr   = run ? ADDR_W'(int'(ky) * int'(k_cfg[2:0]) + int'(kx)) : '0;
    assign out_wr_en   = wr_pipe[MAC_LAT-1];
    assign out_wr_addr = wr_addr;

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = k_illegal ? DONE : RUN;
            RUN:     if (last_tap) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 8'(MAC_LAT)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Configuration latch and tap/window walk.
    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            k_cfg <= '0;
            s_cfg <= '0;
            p_cfg <= '0;
            kx    <= '0;
            ky    <= '0;
            ox0   <= '0;
            oy0   <= '0;
        end else if (start_acc) begin
            k_cfg <= cfg_kernel_size;
            s_cfg <= (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
            p_cfg <= p_new;
            kx    <= '0;
            ky    <= '0;
            ox0   <= -$signed({5'b0, p_new});
            oy0   <= -$signed({5'b0, p_new});
        end else if (run) begin
            if (!kx_end) begin
                kx <= kx + 3'd1;
            end else begin
                kx <= '0;
                if (!ky_end) begin
                    ky <= ky + 3'd1;
                end else begin
                    ky <= '0;
                    if (x_more) begin
                        ox0 <= nx;
                    end else begin
                        ox0 <= -p_s;
                        if (y_more) oy0 <= ny;
                    end
                end
            end
        end
    end

    // Tag pipeline, write scheduling, status.
    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            mac_valid <= 1'b0;
            mac_zero  <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            wr_pipe   <= '0;
            wr_addr   <= '0;
            drain_cnt <= '0;
            err       <= 1'b0;
        end else if (abort) begin
            mac_valid <= 1'b0;
            mac_zero  <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            wr_pipe   <= '0;
            wr_addr   <= '0;
            drain_cnt <= '0;
            err       <= 1'b0;
        end else begin
            mac_valid <= run;
            mac_zero  <= run && pad_tap;
            mac_first <= run && (kx == 3'd0) && (ky == 3'd0);
            mac_last  <= run && kx_end && ky_end;
            wr_pipe   <= (wr_pipe << 1) | MAC_LAT'(mac_last);
            drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : 8'd0;
            if (out_wr_en) wr_addr <= wr_addr + 1'b1;
            if (start_acc) begin
                wr_addr <= '0;
                err     <= 1'b0;
            end else if ((state == LOAD) && k_illegal) begin
                err <= 1'b1;
            end
        end
    end

`ifdef CNNIP_SEQ_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq)                      perf_q <= '0;
        else if (abort || start_acc)        perf_q <= '0;
        else if (busy && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_cnnip_conv_seq.sv
module tb_cnnip_conv_seq;

    localparam int IMG     = 16;
    localparam int MAC_LAT = 2;

    logic       clk_a = 1'b0;
    logic       arstz_aq = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_kernel_size = 8'd3;
    logic [1:0] cfg_stride = 2'd1;
    logic       cfg_padding = 1'b0;
    logic       busy, done, err, in_rd_en, w_rd_en;
    logic [7:0] in_rd_addr, w_rd_addr, out_wr_addr;
    logic       mac_valid, mac_zero, mac_first, mac_last, out_wr_en;
    logic [15:0] perf_cycles;

    cnnip_conv_seq #(.IMG_DIM(IMG), .ADDR_W(8), .MAC_LAT(MAC_LAT)) dut (
        .clk_a(clk_a), .arstz_aq(arstz_aq), .start(start), .abort(abort),
        .cfg_kernel_size(cfg_kernel_size), .cfg_stride(cfg_stride), .cfg_padding(cfg_padding),
        .busy(busy), .done(done), .err(err),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .mac_valid(mac_valid), .mac_zero(mac_zero), .mac_first(mac_first), .mac_last(mac_last),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .perf_cycles(perf_cycles)
    );

    always #5 clk_a = ~clk_a;

    typedef struct packed { logic en; logic [7:0] a; logic [7:0] w; } tap_t;
    typedef struct packed { logic z; logic f; logic l; } tag_t;

    tap_t       tq[$];
    tag_t       mq[$];
    logic [7:0] wq[$];
    tap_t       te;
    tag_t       ge;
    logic [7:0] we;

    int n_chk = 0, n_err = 0, cyc = 0;
    int n_tap, n_wr, first_rd_cyc, last_tap_cyc, mac_last_cyc, last_wr_cyc, done_cyc, done_cnt;
    logic done_err, done_busy;

    always @(posedge clk_a) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: pops expectations as the DUT emits reads, tags and writes.
    always @(negedge clk_a) begin
        if (w_rd_en) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            last_tap_cyc = cyc;
            n_tap++;
            if (tq.size() == 0) chk("tap_unexpected", 32'(w_rd_en), 32'd0);
            else begin
                te = tq.pop_front();
                chk("tap_rd", {15'd0, in_rd_en, in_rd_addr, w_rd_addr}, {15'd0, te});
            end
        end else if (in_rd_en) begin
            chk("rd_en_stray", 32'(in_rd_en), 32'd0);
        end
        if (mac_valid) begin
            if (mac_last) mac_last_cyc = cyc;
            if (mq.size() == 0) chk("tag_unexpected", 32'(mac_valid), 32'd0);
            else begin
                ge = mq.pop_front();
                chk("tag", {29'd0, mac_zero, mac_first, mac_last}, {29'd0, ge});
            end
        end else if (mac_zero || mac_first || mac_last) begin
            chk("tag_stray", {29'd0, mac_zero, mac_first, mac_last}, 32'd0);
        end
        if (out_wr_en) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (wq.size() == 0) chk("wr_unexpected", 32'(out_wr_en), 32'd0);
            else begin
                we = wq.pop_front();
                chk("wr_addr", 32'(out_wr_addr), 32'(we));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_err  = err;
            done_busy = busy;
        end
    end

    // Reference walk of the convolution, written directly from the loop definition.
    task automatic build(input int k, input int s, input int p, output int taps, output int wins);
        int pp, ss, iy, ix;
        bit pad;
        tap_t t;
        tag_t g;
        taps = 0;
        wins = 0;
        if (k % 2 == 1 && k <= 7) begin
            pp = p ? (k - 1) / 2 : 0;
            ss = (s == 0) ? 1 : s;
            for (int oy = -pp; oy + k <= IMG + pp; oy += ss) begin
                for (int ox = -pp; ox + k <= IMG + pp; ox += ss) begin
                    for (int ky = 0; ky < k; ky++) begin
                        for (int kx = 0; kx < k; kx++) begin
                            iy = oy + ky;
                            ix = ox + kx;
                            pad = (iy < 0) || (iy >= IMG) || (ix < 0) || (ix >= IMG);
                            t.en = !pad;
                            t.a  = pad ? 8'd0 : 8'(iy * IMG + ix);
                            t.w  = 8'(ky * k + kx);
                            g.z  = pad;
                            g.f  = (ky == 0) && (kx == 0);
                            g.l  = (ky == k - 1) && (kx == k - 1);
                            tq.push_back(t);
                            mq.push_back(g);
                            taps++;
                        end
                    end
                    wq.push_back(8'(wins));
                    wins++;
                end
            end
        end
    endtask

    task automatic clear_mon();
        n_tap = 0; n_wr = 0; done_cnt = 0;
        first_rd_cyc = -1; last_tap_cyc = -1; mac_last_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
    endtask

    task automatic pulse_start(input int k, input int s, input int p, output int t_load);
        cfg_kernel_size = 8'(k);
        cfg_stride      = 2'(s);
        cfg_padding     = 1'(p);
        @(negedge clk_a) #1;
        start = 1'b1;
        @(negedge clk_a) #1;
        start = 1'b0;
        t_load = cyc;
        chk("busy_load", 32'(busy), 32'd1);
        chk("err_cleared", 32'(err), 32'd0);
    endtask

    task automatic run_conv(input int k, input int s, input int p, input int mid_start);
        int taps, wins, t_load;
        bit legal;
        legal = (k % 2 == 1) && (k <= 7);
        clear_mon();
        build(k, s, p, taps, wins);
        pulse_start(k, s, p, t_load);
        for (int i = 0; i < 6000 && done_cnt == 0; i++) begin
            @(negedge clk_a) #1;
            start = (mid_start > 0 && i == mid_start);
        end
        start = 1'b0;
        chk("done_seen", 32'(done_cnt), 32'd1);
        chk("tap_count", 32'(n_tap), 32'(taps));
        chk("wr_count", 32'(n_wr), 32'(wins));
        chk("done_err", 32'(done_err), 32'(!legal));
        chk("done_busy", 32'(done_busy), 32'd0);
        if (legal) begin
            chk("first_rd_time", 32'(first_rd_cyc), 32'(t_load + 1));
            chk("mac_last_time", 32'(mac_last_cyc), 32'(last_tap_cyc + 1));
            chk("last_wr_time", 32'(last_wr_cyc), 32'(last_tap_cyc + 1 + MAC_LAT));
            chk("done_time", 32'(done_cyc), 32'(last_tap_cyc + 2 + MAC_LAT));
            chk("done_from_first_rd", 32'(done_cyc - first_rd_cyc), 32'(taps + 1 + MAC_LAT));
        end else begin
            chk("done_time_illegal", 32'(done_cyc), 32'(t_load + 1));
        end
        @(negedge clk_a) #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("err_hold", 32'(err), 32'(!legal));
`ifdef CNNIP_SEQ_PERF_EN
        chk("perf_cycles", 32'(perf_cycles), legal ? 32'(taps + MAC_LAT + 2) : 32'd1);
`else
        chk("perf_cycles", 32'(perf_cycles), 32'd0);
`endif
        chk("queues_empty", 32'(tq.size() + mq.size() + wq.size()), 32'd0);
    endtask

    task automatic run_abort();
        int taps, wins, t_load, wr_before;
        clear_mon();
        build(3, 1, 0, taps, wins);
        pulse_start(3, 1, 0, t_load);
        for (int i = 0; i < 500 && n_tap < 100; i++) @(negedge clk_a) #1;
        chk("abort_reached_run", 32'(n_tap), 32'd100);
        abort = 1'b1;
        @(negedge clk_a) #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_strobes", {26'd0, in_rd_en, w_rd_en, mac_valid, out_wr_en, done, err}, 32'd0);
        chk("abort_addrs", {8'd0, in_rd_addr, w_rd_addr, out_wr_addr}, 32'd0);
        chk("abort_perf", 32'(perf_cycles), 32'd0);
        tq.delete();
        mq.delete();
        wq.delete();
        wr_before = n_wr;
        repeat (30) @(negedge clk_a) #1;
        chk("abort_no_wr", 32'(n_wr), 32'(wr_before));
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_no_tap", 32'(tq.size() + mq.size() + wq.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_a);
        chk("rst_status", {29'd0, busy, done, err}, 32'd0);
        chk("rst_strobes", {28'd0, in_rd_en, w_rd_en, mac_valid, out_wr_en}, 32'd0);
        chk("rst_out_addr", 32'(out_wr_addr), 32'd0);
        chk("rst_perf", 32'(perf_cycles), 32'd0);
        arstz_aq = 1'b1;
        repeat (2) @(negedge clk_a);

        run_conv(3, 1, 0, 0);
        run_conv(3, 1, 1, 0);
        run_conv(5, 2, 0, 0);
        run_conv(4, 1, 0, 0);
        run_conv(1, 0, 0, 0);
        run_abort();
        run_conv(3, 1, 0, 0);
        run_conv(3, 1, 0, 50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
